// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants,
// used by the receiver now and by the transmitter later.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Modes other than even/odd (including 3) mean "no parity bit on the line".
  function automatic logic parity_enabled(input int mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so that a serial line can come out of reset in its idle state.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops resolve metastability before the value is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their old inputs on the same edge, giving a true two-stage chain.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: start-bit glitch rejection, DBITS data bits
// LSB first, optional even/odd parity, 1 or 2 stop bits, oversampled on
// s_tick. A complete frame is reported with a one-cycle rx_done strobe.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBITS       = 8,
  parameter int OS_RATE     = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             rx,
  output logic [DBITS-1:0] rx_dout,
  output logic             rx_done,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int OS_W = $clog2(OS_RATE);
  localparam int BC_W = $clog2(DBITS + 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS_RATE - 1);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(DBITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);
  localparam logic            PAR_EN    = parity_enabled(PARITY_MODE);

  generate
    if (DBITS < 5 || DBITS > 9) begin : g_bad_dbits
      $error("uart_rx_cfg: DBITS must be 5..9");
    end
    if (OS_RATE < 8 || OS_RATE > 32 || (OS_RATE % 2) != 0) begin : g_bad_os
      $error("uart_rx_cfg: OS_RATE must be even and 8..32");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic rxs;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  uart_state_t      state, state_n;
  logic [OS_W-1:0]  os_cnt, os_n;
  logic [BC_W-1:0]  bit_cnt, bc_n;
  logic [DBITS-1:0] shreg, sh_n;
  logic             perr_l, perr_n;
  logic             ferr_l, ferr_n;
  logic             done_n;

  // Next-state and datapath update; bit_cnt also counts stop bits.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_n = state;
    os_n    = os_cnt;
    bc_n    = bit_cnt;
    sh_n    = shreg;
    perr_n  = perr_l;
    ferr_n  = ferr_l;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_n = ST_START;
          os_n    = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (os_cnt == OS_HALF) begin
            if (!rxs) begin
              state_n = ST_DATA;
              os_n    = '0;
              bc_n    = '0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            os_n = os_cnt + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (os_cnt == OS_LAST) begin
            os_n = '0;
            sh_n = {rxs, shreg[DBITS-1:1]};
            if (bit_cnt == BC_LAST) begin
              bc_n    = '0;
              state_n = PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              bc_n = bit_cnt + BC_W'(1);
            end
          end else begin
            os_n = os_cnt + OS_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (os_cnt == OS_LAST) begin
            os_n    = '0;
            bc_n    = '0;
            perr_n  = (PARITY_MODE == PARITY_ODD) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
            state_n = ST_STOP;
          end else begin
            os_n = os_cnt + OS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (os_cnt == OS_LAST) begin
            os_n = '0;
            if (!rxs) ferr_n = 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bc_n    = '0;
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              bc_n = bit_cnt + BC_W'(1);
            end
          end else begin
            os_n = os_cnt + OS_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; results publish only on frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr_l     <= 1'b0;
      ferr_l     <= 1'b0;
      rx_dout    <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      bit_cnt <= bc_n;
      shreg   <= sh_n;
      perr_l  <= perr_n;
      ferr_l  <= ferr_n;
      rx_done <= done_n;
      busy    <= (state_n != ST_IDLE);
      if (done_n) begin
        rx_dout    <= sh_n;
        parity_err <= perr_n;
        frame_err  <= ferr_n;
      end else begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) share clock, reset
// and tick; each has its own serial line. Expected frames are queued when
// stimulus is driven and checked by a monitor on every rx_done strobe.
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       s_tick;
  logic [2:0] rx_v;

  logic [7:0] dout0, dout1;
  logic [6:0] dout2;
  logic       done_a [3];
  logic       perr_a [3];
  logic       ferr_a [3];
  logic       busy_a [3];
  logic [8:0] dout_a [3];

  int checks = 0;
  int errors = 0;
  exp_t sb [3][$];
  bit   post [3];

  uart_rx_cfg #(.DBITS(8), .OS_RATE(16), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_v[0]), .rx_dout(dout0),
    .rx_done(done_a[0]), .parity_err(perr_a[0]), .frame_err(ferr_a[0]), .busy(busy_a[0]));

  uart_rx_cfg #(.DBITS(8), .OS_RATE(16), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_v[1]), .rx_dout(dout1),
    .rx_done(done_a[1]), .parity_err(perr_a[1]), .frame_err(ferr_a[1]), .busy(busy_a[1]));

  uart_rx_cfg #(.DBITS(7), .OS_RATE(16), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_v[2]), .rx_dout(dout2),
    .rx_done(done_a[2]), .parity_err(perr_a[2]), .frame_err(ferr_a[2]), .busy(busy_a[2]));

  assign dout_a[0] = {1'b0, dout0};
  assign dout_a[1] = {1'b0, dout1};
  assign dout_a[2] = {2'b00, dout2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock s_tick pulse every 4 clocks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Scoreboard monitor: compare each strobe with the oldest expected frame,
  // and require strobe and flags to be gone one cycle later.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (post[i]) begin
        post[i] = 1'b0;
        checks++;
        if (done_a[i] !== 1'b0 || perr_a[i] !== 1'b0 || ferr_a[i] !== 1'b0) begin
          errors++;
          $display("FAIL strobe_clear dut%0d: done=%b perr=%b ferr=%b, required all 0",
                   i, done_a[i], perr_a[i], ferr_a[i]);
        end
      end
      if (done_a[i] === 1'b1) begin
        post[i] = 1'b1;
        checks++;
        if (sb[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe dut%0d: data=%h, no frame expected", i, dout_a[i]);
        end else begin
          exp_t e;
          e = sb[i].pop_front();
          if (dout_a[i] !== e.data || perr_a[i] !== e.perr || ferr_a[i] !== e.ferr) begin
            errors++;
            $display("FAIL frame dut%0d: data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                     i, dout_a[i], perr_a[i], ferr_a[i], e.data, e.perr, e.ferr);
          end
        end
      end
    end
  end

  task automatic drive_bit(input int sel, input logic val, input int clks);
    rx_v[sel] = val;
    repeat (clks) @(negedge clk);
  endtask

  // Send one frame on line sel; a bad stop bit is low past mid-bit then
  // returns high so the line idles afterwards.
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input int pmode, input logic par_bit, input int nstop,
                            input logic stop_ok, input bit push);
    exp_t e;
    logic [8:0] dm;
    int ones;
    dm = data & ((9'd1 << nbits) - 9'd1);
    ones = $countones(dm) + int'(par_bit);
    e.data = dm;
    e.perr = (pmode == 1) ? (ones % 2 == 1) : (pmode == 2) ? (ones % 2 == 0) : 1'b0;
    e.ferr = ~stop_ok;
    if (push) sb[sel].push_back(e);
    drive_bit(sel, 1'b0, BIT_CLKS);
    for (int b = 0; b < nbits; b++) drive_bit(sel, dm[b], BIT_CLKS);
    if (pmode == 1 || pmode == 2) drive_bit(sel, par_bit, BIT_CLKS);
    for (int s = 0; s < nstop; s++) begin
      if (stop_ok) drive_bit(sel, 1'b1, BIT_CLKS);
      else begin
        drive_bit(sel, 1'b0, 40);
        drive_bit(sel, 1'b1, BIT_CLKS - 40);
      end
    end
  endtask

  task automatic wait_drain(input int sel, input string name);
    for (int k = 0; k < 400 && sb[sel].size() != 0; k++) @(negedge clk);
    checks++;
    if (sb[sel].size() != 0) begin
      errors++;
      $display("FAIL %s dut%0d: %0d frames never strobed, required 0", name, sel, sb[sel].size());
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rx_v = 3'b111;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dout_a[i], done_a[i], perr_a[i], ferr_a[i], busy_a[i]} !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: dout=%h done=%b perr=%b ferr=%b busy=%b, required all 0",
                 i, dout_a[i], done_a[i], perr_a[i], ferr_a[i], busy_a[i]);
      end
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_a[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle dut%0d: busy=%b, required 0", i, busy_a[i]);
      end
    end
  endtask

  task automatic test_basic();
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    wait_drain(0, "basic");
  endtask

  task automatic test_glitch();
    drive_bit(0, 1'b0, 20);
    checks++;
    if (busy_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_high: busy=%b, required 1", busy_a[0]);
    end
    drive_bit(0, 1'b1, BIT_CLKS);
    checks++;
    if (busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_low: busy=%b, required 0", busy_a[0]);
    end
    checks++;
    if (dout_a[0] !== 9'h0A5) begin
      errors++;
      $display("FAIL glitch_dout_hold: dout=%h, required 0a5", dout_a[0]);
    end
  endtask

  task automatic test_parity();
    send_frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1, 1'b1);
    drive_bit(1, 1'b1, BIT_CLKS);
    send_frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(1, 1'b1, BIT_CLKS);
    wait_drain(1, "parity");
  endtask

  task automatic test_frame_err();
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0, 1'b1);
    drive_bit(0, 1'b1, 2 * BIT_CLKS);
    send_frame(0, 9'h066, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, BIT_CLKS);
    wait_drain(0, "frame_err");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_frame(0, 9'h000, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        send_frame(0, 9'h081, 8, 0, 1'b0, 1, 1'b1, 1'b1);
      end
      begin
        repeat (300) @(negedge clk);
        checks++;
        if (dout_a[0] !== 9'h066) begin
          errors++;
          $display("FAIL dout_mid_frame: dout=%h, required 066", dout_a[0]);
        end
      end
    join
    drive_bit(0, 1'b1, BIT_CLKS);
    wait_drain(0, "back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h5A;
    drive_bit(0, 1'b0, BIT_CLKS);
    for (int b = 0; b < 4; b++) drive_bit(0, d[b], BIT_CLKS);
    drive_bit(0, d[4], 32);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dout_a[0], done_a[0], perr_a[0], ferr_a[0], busy_a[0]} !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid_frame: dout=%h done=%b perr=%b ferr=%b busy=%b, required all 0",
               dout_a[0], done_a[0], perr_a[0], ferr_a[0], busy_a[0]);
    end
    rx_v[0] = 1'b1;
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    checks++;
    if (busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_frame_idle: busy=%b, required 0", busy_a[0]);
    end
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, BIT_CLKS);
    wait_drain(0, "after_reset");
  endtask

  task automatic test_cfg_7o2();
    // 7'h55 has four ones, so odd parity needs a 1 on the line.
    send_frame(2, 9'h055, 7, 2, 1'b1, 2, 1'b1, 1'b1);
    drive_bit(2, 1'b1, BIT_CLKS);
    send_frame(2, 9'h055, 7, 2, 1'b0, 2, 1'b1, 1'b1);
    drive_bit(2, 1'b1, BIT_CLKS);
    wait_drain(2, "cfg_7o2");
  endtask

  initial begin
    post[0] = 1'b0;
    post[1] = 1'b0;
    post[2] = 1'b0;
    rst = 1'b1;
    rx_v = 3'b111;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_cfg_7o2();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
